// File: rtl/lc3_control_fsm.sv
// LC-3 instruction sequencer and decoder for the lab CPU datapath.
// Walks fetch / decode / execute states and drives every datapath load
// enable, bus gate, mux select and SRAM strobe. SRAM accesses are held
// for MEM_WAIT cycles by a shared wait counter. Opcode 1101 is PAUSE
// when PAUSE_EN is set. Undefined opcodes park the sequencer in ERROR
// until Reset.
module lc3_control_fsm #(
  parameter int MEM_WAIT = 2,
  parameter bit PAUSE_EN = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE,
  output logic       Mem_UB,
  output logic       Mem_LB,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Illegal
);

  typedef enum logic [4:0] {
    HALTED, F1, FMEM, FIR, DEC,
    S_ADD, S_AND, S_NOT, S_LEA,
    S_LD, S_LDR, S_LDI, IMEM, IMAR, MEMR, RDR,
    S_ST, S_STR, S_STI, SMEM, SMAR, SMDR, MEMW,
    S_JSR, J21, J20, S_JMP, S_BR, BRT,
    PAUSE1, PAUSE2, ERROR
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  state_t     state, next_state;
  logic [3:0] wait_cnt;
  logic       in_mem;
  logic       wait_done;

  assign in_mem    = state inside {FMEM, IMEM, SMEM, MEMR, MEMW};
  assign wait_done = (wait_cnt == WAIT_LAST);

  assign Mem_CE = 1'b0;
  assign Mem_UB = 1'b0;
  assign Mem_LB = 1'b0;

  // State register and wait counter; the counter is zero whenever a memory state is entered.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= HALTED;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (in_mem && !wait_done) wait_cnt <= wait_cnt + 4'd1;
      else                      wait_cnt <= '0;
    end
  end

  // Next-state selection from the current state, decoded opcode and handshake inputs.
  always_comb begin
    next_state = state;
    case (state)
      HALTED: if (Run) next_state = F1;
      F1:     next_state = FMEM;
      FMEM:   if (wait_done) next_state = FIR;
      FIR:    next_state = DEC;
      DEC: begin
        case (Opcode)
          4'b0001: next_state = S_ADD;
          4'b0101: next_state = S_AND;
          4'b1001: next_state = S_NOT;
          4'b0010: next_state = S_LD;
          4'b0110: next_state = S_LDR;
          4'b1010: next_state = S_LDI;
          4'b0011: next_state = S_ST;
          4'b0111: next_state = S_STR;
          4'b1011: next_state = S_STI;
          4'b1110: next_state = S_LEA;
          4'b0000: next_state = S_BR;
          4'b1100: next_state = S_JMP;
          4'b0100: next_state = S_JSR;
          4'b1101: next_state = PAUSE_EN ? PAUSE1 : ERROR;
          default: next_state = ERROR;
        endcase
      end
      S_ADD, S_AND, S_NOT, S_LEA: next_state = F1;
      S_LD, S_LDR: next_state = MEMR;
      S_LDI:  next_state = IMEM;
      IMEM:   if (wait_done) next_state = IMAR;
      IMAR:   next_state = MEMR;
      MEMR:   if (wait_done) next_state = RDR;
      RDR:    next_state = F1;
      S_ST, S_STR: next_state = SMDR;
      S_STI:  next_state = SMEM;
      SMEM:   if (wait_done) next_state = SMAR;
      SMAR:   next_state = SMDR;
      SMDR:   next_state = MEMW;
      MEMW:   if (wait_done) next_state = F1;
      S_JSR:  next_state = IR_11 ? J21 : J20;
      J21, J20, S_JMP: next_state = F1;
      S_BR:   next_state = BEN ? BRT : F1;
      BRT:    next_state = F1;
      PAUSE1: if (Continue) next_state = PAUSE2;
      PAUSE2: if (!Continue) next_state = F1;
      ERROR:  next_state = ERROR;
      default: next_state = HALTED;
    endcase
  end

  // Datapath controls decoded from state; anything not driven below stays inactive.
  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    Illegal    = 1'b0;
    case (state)
      F1: begin
        GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1;
      end
      FMEM, IMEM, SMEM, MEMR: begin
        Mem_OE = 1'b0;
        LD_MDR = wait_done;
      end
      FIR: begin
        GateMDR = 1'b1; LD_IR = 1'b1;
      end
      DEC: LD_BEN = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        SR2MUX  = (state == S_NOT) ? 1'b0 : IR_5;
        ALUK    = (state == S_ADD) ? 2'b00 : (state == S_AND) ? 2'b01 : 2'b11;
      end
      S_LEA: begin
        ADDR2MUX = 2'b10; GateMARMUX = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
      end
      S_LD, S_LDI, S_ST, S_STI: begin
        ADDR2MUX = 2'b10; GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      S_LDR, S_STR: begin
        ADDR1MUX = 1'b1; ADDR2MUX = 2'b01; GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      IMAR, SMAR: begin
        GateMDR = 1'b1; LD_MAR = 1'b1;
      end
      RDR: begin
        GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
      end
      SMDR: begin
        SR1MUX = 1'b1; ALUK = 2'b10; GateALU = 1'b1; LD_MDR = 1'b1;
      end
      MEMW: Mem_WE = 1'b0;
      S_JSR: begin
        GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1;
      end
      J21: begin
        ADDR2MUX = 2'b11; PCMUX = 2'b01; LD_PC = 1'b1;
      end
      J20, S_JMP: begin
        ADDR1MUX = 1'b1; PCMUX = 2'b01; LD_PC = 1'b1;
      end
      BRT: begin
        ADDR2MUX = 2'b10; PCMUX = 2'b01; LD_PC = 1'b1;
      end
      PAUSE1: LD_LED = 1'b1;
      ERROR:  Illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed bench for lc3_control_fsm. Instance a uses MEM_WAIT=2 with PAUSE
// enabled, instance b uses MEM_WAIT=3 with PAUSE disabled. Every cycle the
// full control word is compared against a hand-written table of the
// expected outputs for each symbolic step.
module tb_lc3_control_fsm;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1, Run = 1'b0, Continue = 1'b0;
  logic [3:0] Opcode = 4'b0000;
  logic       IR_5 = 1'b0, IR_11 = 1'b0, BEN = 1'b0;

  logic LD_MAR_a, LD_MDR_a, LD_IR_a, LD_BEN_a, LD_CC_a, LD_REG_a, LD_PC_a, LD_LED_a;
  logic GatePC_a, GateMDR_a, GateALU_a, GateMARMUX_a, DRMUX_a, SR1MUX_a, SR2MUX_a, ADDR1MUX_a;
  logic [1:0] PCMUX_a, ADDR2MUX_a, ALUK_a;
  logic Mem_CE_a, Mem_UB_a, Mem_LB_a, Mem_OE_a, Mem_WE_a, Illegal_a;

  logic LD_MAR_b, LD_MDR_b, LD_IR_b, LD_BEN_b, LD_CC_b, LD_REG_b, LD_PC_b, LD_LED_b;
  logic GatePC_b, GateMDR_b, GateALU_b, GateMARMUX_b, DRMUX_b, SR1MUX_b, SR2MUX_b, ADDR1MUX_b;
  logic [1:0] PCMUX_b, ADDR2MUX_b, ALUK_b;
  logic Mem_CE_b, Mem_UB_b, Mem_LB_b, Mem_OE_b, Mem_WE_b, Illegal_b;

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic mem_ce, mem_ub, mem_lb, mem_oe, mem_we, illegal;
  } ctl_t;

  typedef enum {
    T_IDLE, T_F1, T_RD, T_RDL, T_FIR, T_DEC, T_ADDI, T_ANDR, T_NOT, T_LEA,
    T_LD, T_LDR, T_MAR2, T_RDR, T_SMDR, T_WR, T_JSR, T_J21, T_J20, T_BRT,
    T_P1, T_ERR
  } tst_t;

  ctl_t obs_a, obs_b;
  int   checks = 0;
  int   failures = 0;

  assign obs_a = {LD_MAR_a, LD_MDR_a, LD_IR_a, LD_BEN_a, LD_CC_a, LD_REG_a, LD_PC_a, LD_LED_a,
                  GatePC_a, GateMDR_a, GateALU_a, GateMARMUX_a, PCMUX_a,
                  DRMUX_a, SR1MUX_a, SR2MUX_a, ADDR1MUX_a, ADDR2MUX_a, ALUK_a,
                  Mem_CE_a, Mem_UB_a, Mem_LB_a, Mem_OE_a, Mem_WE_a, Illegal_a};
  assign obs_b = {LD_MAR_b, LD_MDR_b, LD_IR_b, LD_BEN_b, LD_CC_b, LD_REG_b, LD_PC_b, LD_LED_b,
                  GatePC_b, GateMDR_b, GateALU_b, GateMARMUX_b, PCMUX_b,
                  DRMUX_b, SR1MUX_b, SR2MUX_b, ADDR1MUX_b, ADDR2MUX_b, ALUK_b,
                  Mem_CE_b, Mem_UB_b, Mem_LB_b, Mem_OE_b, Mem_WE_b, Illegal_b};

  lc3_control_fsm #(.MEM_WAIT(2), .PAUSE_EN(1'b1)) dut_a (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR_a), .LD_MDR(LD_MDR_a), .LD_IR(LD_IR_a), .LD_BEN(LD_BEN_a),
    .LD_CC(LD_CC_a), .LD_REG(LD_REG_a), .LD_PC(LD_PC_a), .LD_LED(LD_LED_a),
    .GatePC(GatePC_a), .GateMDR(GateMDR_a), .GateALU(GateALU_a), .GateMARMUX(GateMARMUX_a),
    .PCMUX(PCMUX_a), .DRMUX(DRMUX_a), .SR1MUX(SR1MUX_a), .SR2MUX(SR2MUX_a),
    .ADDR1MUX(ADDR1MUX_a), .ADDR2MUX(ADDR2MUX_a), .ALUK(ALUK_a),
    .Mem_CE(Mem_CE_a), .Mem_UB(Mem_UB_a), .Mem_LB(Mem_LB_a),
    .Mem_OE(Mem_OE_a), .Mem_WE(Mem_WE_a), .Illegal(Illegal_a)
  );

  lc3_control_fsm #(.MEM_WAIT(3), .PAUSE_EN(1'b0)) dut_b (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR_b), .LD_MDR(LD_MDR_b), .LD_IR(LD_IR_b), .LD_BEN(LD_BEN_b),
    .LD_CC(LD_CC_b), .LD_REG(LD_REG_b), .LD_PC(LD_PC_b), .LD_LED(LD_LED_b),
    .GatePC(GatePC_b), .GateMDR(GateMDR_b), .GateALU(GateALU_b), .GateMARMUX(GateMARMUX_b),
    .PCMUX(PCMUX_b), .DRMUX(DRMUX_b), .SR1MUX(SR1MUX_b), .SR2MUX(SR2MUX_b),
    .ADDR1MUX(ADDR1MUX_b), .ADDR2MUX(ADDR2MUX_b), .ALUK(ALUK_b),
    .Mem_CE(Mem_CE_b), .Mem_UB(Mem_UB_b), .Mem_LB(Mem_LB_b),
    .Mem_OE(Mem_OE_b), .Mem_WE(Mem_WE_b), .Illegal(Illegal_b)
  );

  always #5 Clk = ~Clk;

  // Expected control word for each symbolic step, written from the datapath description.
  function automatic ctl_t exp_ctl(input tst_t s);
    ctl_t c;
    c = '0;
    c.mem_oe = 1'b1;
    c.mem_we = 1'b1;
    case (s)
      T_F1:   begin c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; end
      T_RD:   c.mem_oe = 0;
      T_RDL:  begin c.mem_oe = 0; c.ld_mdr = 1; end
      T_FIR:  begin c.gate_mdr = 1; c.ld_ir = 1; end
      T_DEC:  c.ld_ben = 1;
      T_ADDI: begin c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.sr2mux = 1; c.aluk = 2'b00; end
      T_ANDR: begin c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.aluk = 2'b01; end
      T_NOT:  begin c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.aluk = 2'b11; end
      T_LEA:  begin c.gate_marmux = 1; c.ld_reg = 1; c.ld_cc = 1; c.addr2mux = 2'b10; end
      T_LD:   begin c.gate_marmux = 1; c.ld_mar = 1; c.addr2mux = 2'b10; end
      T_LDR:  begin c.gate_marmux = 1; c.ld_mar = 1; c.addr1mux = 1; c.addr2mux = 2'b01; end
      T_MAR2: begin c.gate_mdr = 1; c.ld_mar = 1; end
      T_RDR:  begin c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; end
      T_SMDR: begin c.sr1mux = 1; c.aluk = 2'b10; c.gate_alu = 1; c.ld_mdr = 1; end
      T_WR:   c.mem_we = 0;
      T_JSR:  begin c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; end
      T_J21:  begin c.addr2mux = 2'b11; c.pcmux = 2'b01; c.ld_pc = 1; end
      T_J20:  begin c.addr1mux = 1; c.pcmux = 2'b01; c.ld_pc = 1; end
      T_BRT:  begin c.addr2mux = 2'b10; c.pcmux = 2'b01; c.ld_pc = 1; end
      T_P1:   c.ld_led = 1;
      T_ERR:  c.illegal = 1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Resets both instances into HALTED with the instruction fields loaded and Run raised.
  task automatic begin_instr(input logic [3:0] op, input logic ir5, input logic ir11, input logic ben);
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
    Opcode = op; IR_5 = ir5; IR_11 = ir11; BEN = ben;
    tick();
    Reset = 1'b0;
    Run = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Run = 1'b1;
    tick();
    checks++;
    if (obs_a !== exp_ctl(T_IDLE)) begin
      failures++; $display("[TB] FAIL reset_a: got %h expected %h", obs_a, exp_ctl(T_IDLE));
    end
    checks++;
    if (obs_b !== exp_ctl(T_IDLE)) begin
      failures++; $display("[TB] FAIL reset_b: got %h expected %h", obs_b, exp_ctl(T_IDLE));
    end
    tick();
    checks++;
    if (obs_a !== exp_ctl(T_IDLE)) begin
      failures++; $display("[TB] FAIL reset_prio_run: got %h expected %h", obs_a, exp_ctl(T_IDLE));
    end
    Reset = 1'b0; Run = 1'b0;
    tick();
    checks++;
    if (obs_a !== exp_ctl(T_IDLE)) begin
      failures++; $display("[TB] FAIL halted_hold: got %h expected %h", obs_a, exp_ctl(T_IDLE));
    end
  endtask

  task automatic test_alu_ops();
    tst_t seq_add [7];
    tst_t seq_and [7];
    tst_t seq_not [7];
    int oe_low, mdr_hi;
    seq_add = '{T_F1, T_RD, T_RDL, T_FIR, T_DEC, T_ADDI, T_F1};
    seq_and = '{T_F1, T_RD, T_RDL, T_FIR, T_DEC, T_ANDR, T_F1};
    seq_not = '{T_F1, T_RD, T_RDL, T_FIR, T_DEC, T_NOT, T_F1};
    begin_instr(4'b0001, 1'b1, 1'b0, 1'b0);
    oe_low = 0; mdr_hi = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i < 6 && obs_a.mem_oe == 1'b0) oe_low++;
      if (i < 6 && obs_a.ld_mdr == 1'b1) mdr_hi++;
      checks++;
      if (obs_a !== exp_ctl(seq_add[i])) begin
        failures++; $display("[TB] FAIL add step %0d: got %h expected %h", i, obs_a, exp_ctl(seq_add[i]));
      end
    end
    checks++;
    if (oe_low != 2) begin
      failures++; $display("[TB] FAIL add_oe_cycles: got %0d expected 2", oe_low);
    end
    checks++;
    if (mdr_hi != 1) begin
      failures++; $display("[TB] FAIL add_ldmdr_cycles: got %0d expected 1", mdr_hi);
    end
    begin_instr(4'b0101, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_ctl(seq_and[i])) begin
        failures++; $display("[TB] FAIL and step %0d: got %h expected %h", i, obs_a, exp_ctl(seq_and[i]));
      end
    end
    begin_instr(4'b1001, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_ctl(seq_not[i])) begin
        failures++; $display("[TB] FAIL not step %0d: got %h expected %h", i, obs_a, exp_ctl(seq_not[i]));
      end
    end
  endtask

  task automatic test_store_wait3();
    tst_t seq [12];
    int we_low;
    seq = '{T_F1, T_RD, T_RD, T_RDL, T_FIR, T_DEC, T_LDR, T_SMDR, T_WR, T_WR, T_WR, T_F1};
    begin_instr(4'b0111, 1'b0, 1'b0, 1'b0);
    we_low = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (obs_b.mem_we == 1'b0 && obs_b.mem_oe == 1'b1) we_low++;
      checks++;
      if (obs_b !== exp_ctl(seq[i])) begin
        failures++; $display("[TB] FAIL str_w3 step %0d: got %h expected %h", i, obs_b, exp_ctl(seq[i]));
      end
    end
    checks++;
    if (we_low != 3) begin
      failures++; $display("[TB] FAIL str_we_cycles: got %0d expected 3", we_low);
    end
  endtask

  task automatic test_load_family();
    tst_t seq_ldi [13];
    tst_t seq_ld  [10];
    tst_t seq_sti [13];
    tst_t seq_lea [7];
    seq_ldi = '{T_F1, T_RD, T_RDL, T_FIR, T_DEC, T_LD, T_RD, T_RDL, T_MAR2, T_RD, T_RDL, T_RDR, T_F1};
    seq_ld  = '{T_F1, T_RD, T_RDL, T_FIR, T_DEC, T_LD, T_RD, T_RDL, T_RDR, T_F1};
    seq_sti = '{T_F1, T_RD, T_RDL, T_FIR, T_DEC, T_LD, T_RD, T_RDL, T_MAR2, T_SMDR, T_WR, T_WR, T_F1};
    seq_lea = '{T_F1, T_RD, T_RDL, T_FIR, T_DEC, T_LEA, T_F1};
    begin_instr(4'b1010, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_ctl(seq_ldi[i])) begin
        failures++; $display("[TB] FAIL ldi step %0d: got %h expected %h", i, obs_a, exp_ctl(seq_ldi[i]));
      end
    end
    begin_instr(4'b0010, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_ctl(seq_ld[i])) begin
        failures++; $display("[TB] FAIL ld step %0d: got %h expected %h", i, obs_a, exp_ctl(seq_ld[i]));
      end
    end
    begin_instr(4'b1011, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_ctl(seq_sti[i])) begin
        failures++; $display("[TB] FAIL sti step %0d: got %h expected %h", i, obs_a, exp_ctl(seq_sti[i]));
      end
    end
    begin_instr(4'b1110, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_ctl(seq_lea[i])) begin
        failures++; $display("[TB] FAIL lea step %0d: got %h expected %h", i, obs_a, exp_ctl(seq_lea[i]));
      end
    end
  endtask

  task automatic test_branch();
    tst_t seq_nt [7];
    tst_t seq_tk [8];
    seq_nt = '{T_F1, T_RD, T_RDL, T_FIR, T_DEC, T_IDLE, T_F1};
    seq_tk = '{T_F1, T_RD, T_RDL, T_FIR, T_DEC, T_IDLE, T_BRT, T_F1};
    begin_instr(4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_ctl(seq_nt[i])) begin
        failures++; $display("[TB] FAIL br_not_taken step %0d: got %h expected %h", i, obs_a, exp_ctl(seq_nt[i]));
      end
    end
    begin_instr(4'b0000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_ctl(seq_tk[i])) begin
        failures++; $display("[TB] FAIL br_taken step %0d: got %h expected %h", i, obs_a, exp_ctl(seq_tk[i]));
      end
    end
  endtask

  task automatic test_jumps();
    tst_t seq_j0 [8];
    tst_t seq_j1 [8];
    tst_t seq_jmp [7];
    seq_j0  = '{T_F1, T_RD, T_RDL, T_FIR, T_DEC, T_JSR, T_J20, T_F1};
    seq_j1  = '{T_F1, T_RD, T_RDL, T_FIR, T_DEC, T_JSR, T_J21, T_F1};
    seq_jmp = '{T_F1, T_RD, T_RDL, T_FIR, T_DEC, T_J20, T_F1};
    begin_instr(4'b0100, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_ctl(seq_j0[i])) begin
        failures++; $display("[TB] FAIL jsrr step %0d: got %h expected %h", i, obs_a, exp_ctl(seq_j0[i]));
      end
    end
    begin_instr(4'b0100, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_ctl(seq_j1[i])) begin
        failures++; $display("[TB] FAIL jsr step %0d: got %h expected %h", i, obs_a, exp_ctl(seq_j1[i]));
      end
    end
    begin_instr(4'b1100, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_ctl(seq_jmp[i])) begin
        failures++; $display("[TB] FAIL jmp step %0d: got %h expected %h", i, obs_a, exp_ctl(seq_jmp[i]));
      end
    end
  endtask

  task automatic test_pause();
    tst_t seq [5];
    seq = '{T_F1, T_RD, T_RDL, T_FIR, T_DEC};
    begin_instr(4'b1101, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_ctl(seq[i])) begin
        failures++; $display("[TB] FAIL pause_fetch step %0d: got %h expected %h", i, obs_a, exp_ctl(seq[i]));
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_ctl(T_P1)) begin
        failures++; $display("[TB] FAIL pause1 cycle %0d: got %h expected %h", i, obs_a, exp_ctl(T_P1));
      end
    end
    Continue = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_ctl(T_IDLE)) begin
        failures++; $display("[TB] FAIL pause2 cycle %0d: got %h expected %h", i, obs_a, exp_ctl(T_IDLE));
      end
    end
    Continue = 1'b0;
    tick();
    checks++;
    if (obs_a !== exp_ctl(T_F1)) begin
      failures++; $display("[TB] FAIL pause_release: got %h expected %h", obs_a, exp_ctl(T_F1));
    end
  endtask

  task automatic test_illegal();
    tst_t seq_a [5];
    tst_t seq_b [7];
    seq_a = '{T_F1, T_RD, T_RDL, T_FIR, T_DEC};
    seq_b = '{T_F1, T_RD, T_RD, T_RDL, T_FIR, T_DEC, T_ERR};
    begin_instr(4'b1111, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_ctl(seq_a[i])) begin
        failures++; $display("[TB] FAIL illegal_fetch step %0d: got %h expected %h", i, obs_a, exp_ctl(seq_a[i]));
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      Run = i[0];
      Continue = i[1];
      checks++;
      if (obs_a !== exp_ctl(T_ERR)) begin
        failures++; $display("[TB] FAIL error_hold cycle %0d: got %h expected %h", i, obs_a, exp_ctl(T_ERR));
      end
    end
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
    tick();
    Reset = 1'b0;
    checks++;
    if (obs_a !== exp_ctl(T_IDLE)) begin
      failures++; $display("[TB] FAIL error_reset: got %h expected %h", obs_a, exp_ctl(T_IDLE));
    end
    begin_instr(4'b1101, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (obs_b !== exp_ctl(seq_b[i])) begin
        failures++; $display("[TB] FAIL pause_disabled step %0d: got %h expected %h", i, obs_b, exp_ctl(seq_b[i]));
      end
    end
  endtask

  task automatic test_reset_mid_write();
    tst_t seq [9];
    seq = '{T_F1, T_RD, T_RDL, T_FIR, T_DEC, T_LD, T_SMDR, T_WR, T_WR};
    begin_instr(4'b0011, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (obs_a !== exp_ctl(seq[i])) begin
        failures++; $display("[TB] FAIL st step %0d: got %h expected %h", i, obs_a, exp_ctl(seq[i]));
      end
    end
    Reset = 1'b1;
    tick();
    checks++;
    if (obs_a !== exp_ctl(T_IDLE)) begin
      failures++; $display("[TB] FAIL reset_mid_write: got %h expected %h", obs_a, exp_ctl(T_IDLE));
    end
    Reset = 1'b0; Run = 1'b0;
  endtask

  // Runs every scenario in order, then prints the summary line.
  initial begin
    test_reset();
    test_alu_ops();
    test_store_wait3();
    test_load_family();
    test_branch();
    test_jumps();
    test_pause();
    test_illegal();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guards against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
